// File: rtl/pinball_pkg.sv
// Shared pinball types and constants: fixed-point formats, screen size, ball FSM states.
package pinball_pkg;

  localparam int unsigned FIXED_SHIFT   = 6;
  localparam int unsigned SCREEN_WIDTH  = 640;
  localparam int unsigned SCREEN_HEIGHT = 480;

  localparam int unsigned PIXEL_W = 11;
  localparam int unsigned POS_W   = 18;
  localparam int unsigned SPEED_W = 16;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SPEED   = 2'd1,
    POS     = 2'd2
  } ball_state_t;

  typedef logic signed [POS_W-1:0]   fixed_pos_t;
  typedef logic signed [SPEED_W-1:0] fixed_speed_t;

  // Integer pixel coordinate of a fixed-point position (arithmetic shift, then truncate).
  function automatic logic [PIXEL_W-1:0] to_pixel(input fixed_pos_t pos);
    return PIXEL_W'(pos >>> FIXED_SHIFT);
  endfunction

endpackage

// File: rtl/collision_side_detector.sv
// Classifies border/flipper collision pixels by ball quadrant and keeps sticky hit flags.
module collision_side_detector
  import pinball_pkg::*;
#(
  parameter int unsigned OBJECT_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 enable,
  input  logic                 clear,
  input  logic [PIXEL_W-1:0]   pixelX,
  input  logic [PIXEL_W-1:0]   pixelY,
  input  logic [PIXEL_W-1:0]   topLeftX,
  input  logic [PIXEL_W-1:0]   topLeftY,
  input  logic                 collisionBorders,
  input  logic                 collisionFlipper,
  output logic                 hitLeft,
  output logic                 hitRight,
  output logic                 hitTop,
  output logic                 hitBottom,
  output logic                 hitFlip
);

  localparam logic [PIXEL_W-1:0] HALF_SIZE = PIXEL_W'(OBJECT_SIZE / 2);

  logic [PIXEL_W-1:0] dx;
  logic [PIXEL_W-1:0] dy;
  logic               border_c;
  logic               flip_c;
  logic               left_c;
  logic               right_c;
  logic               top_c;
  logic               bottom_c;

  // Offset of the colliding pixel inside the ball picks the side that was struck.
  always_comb begin
    dx       = pixelX - topLeftX;
    dy       = pixelY - topLeftY;
    border_c = enable & collisionBorders;
    flip_c   = enable & collisionFlipper;
    left_c   = border_c & (dx <  HALF_SIZE);
    right_c  = border_c & (dx >= HALF_SIZE);
    top_c    = border_c & (dy <  HALF_SIZE);
    bottom_c = border_c & (dy >= HALF_SIZE);
  end

  // Sticky flags; on clear the old frame is dropped but a same-cycle hit starts the new one.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hitLeft   <= 1'b0;
      hitRight  <= 1'b0;
      hitTop    <= 1'b0;
      hitBottom <= 1'b0;
      hitFlip   <= 1'b0;
    end else if (clear) begin
      hitLeft   <= left_c;
      hitRight  <= right_c;
      hitTop    <= top_c;
      hitBottom <= bottom_c;
      hitFlip   <= flip_c;
    end else begin
      hitLeft   <= hitLeft   | left_c;
      hitRight  <= hitRight  | right_c;
      hitTop    <= hitTop    | top_c;
      hitBottom <= hitBottom | bottom_c;
      hitFlip   <= hitFlip   | flip_c;
    end
  end

endmodule

// File: rtl/ball_motion.sv
// Per-frame ball motion: collects side hits during scan, then updates speed and position.
module ball_motion
  import pinball_pkg::*;
#(
  parameter int          INIT_X       = 280,
  parameter int          INIT_Y       = 185,
  parameter int          INIT_X_SPEED = 40,
  parameter int          INIT_Y_SPEED = -60,
  parameter int          GRAVITY      = 1,
  parameter int          MAX_Y_SPEED  = 380,
  parameter int          FLIPPER_KICK = 300,
  parameter int unsigned OBJECT_SIZE  = 32
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic [10:0]        pixelX,
  input  logic [10:0]        pixelY,
  input  logic               collisionBorders,
  input  logic               collisionFlipper,
  input  logic               pause,
  output logic [10:0]        topLeftX,
  output logic [10:0]        topLeftY,
  output logic               flipperHit
);

  localparam fixed_pos_t   INIT_POS_X   = POS_W'(INIT_X * (2 ** FIXED_SHIFT));
  localparam fixed_pos_t   INIT_POS_Y   = POS_W'(INIT_Y * (2 ** FIXED_SHIFT));
  localparam fixed_speed_t INIT_SPEED_X = SPEED_W'(INIT_X_SPEED);
  localparam fixed_speed_t INIT_SPEED_Y = SPEED_W'(INIT_Y_SPEED);
  localparam fixed_speed_t KICK_SPEED   = SPEED_W'(-FLIPPER_KICK);
  localparam logic signed [SPEED_W:0] GRAVITY_W = (SPEED_W+1)'(GRAVITY);
  localparam logic signed [SPEED_W:0] MAX_Y_W   = (SPEED_W+1)'(MAX_Y_SPEED);

  ball_state_t  state;
  ball_state_t  next_state;

  fixed_pos_t   pos_x;
  fixed_pos_t   pos_y;
  fixed_speed_t x_speed;
  fixed_speed_t y_speed;
  fixed_speed_t x_speed_nxt;
  fixed_speed_t y_speed_nxt;

  logic live_left, live_right, live_top, live_bottom, live_flip;
  logic snap_left, snap_right, snap_top, snap_bottom, snap_flip;

  logic snapshot_c;
  logic speed_en_c;
  logic pos_en_c;
  logic flipper_hit_nxt_c;

  logic x_neg_c, x_pos_c, y_neg_c, y_pos_c;
  logic signed [SPEED_W:0] y_grav;

  assign topLeftX = to_pixel(pos_x);
  assign topLeftY = to_pixel(pos_y);

  collision_side_detector #(
    .OBJECT_SIZE (OBJECT_SIZE)
  ) u_det (
    .clk              (clk),
    .resetN           (resetN),
    .enable           (state == COLLECT),
    .clear            (snapshot_c),
    .pixelX           (pixelX),
    .pixelY           (pixelY),
    .topLeftX         (topLeftX),
    .topLeftY         (topLeftY),
    .collisionBorders (collisionBorders),
    .collisionFlipper (collisionFlipper),
    .hitLeft          (live_left),
    .hitRight         (live_right),
    .hitTop           (live_top),
    .hitBottom        (live_bottom),
    .hitFlip          (live_flip)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= COLLECT;
    else         state <= next_state;
  end

  // Next state: wait for frame start, then one cycle each for speed and position.
  always_comb begin
    next_state = state;
    unique case (state)
      COLLECT: if (startOfFrame) next_state = SPEED;
      SPEED:   next_state = POS;
      POS:     next_state = COLLECT;
      default: next_state = COLLECT;
    endcase
  end

  // Per-state control strobes.
  always_comb begin
    snapshot_c        = 1'b0;
    speed_en_c        = 1'b0;
    pos_en_c          = 1'b0;
    flipper_hit_nxt_c = 1'b0;
    unique case (state)
      COLLECT: snapshot_c = startOfFrame;
      SPEED: begin
        speed_en_c        = ~pause;
        flipper_hit_nxt_c = snap_flip;
      end
      POS:     pos_en_c = ~pause;
      default: ;
    endcase
  end

  // Frame snapshot of the hit flags.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      snap_left   <= 1'b0;
      snap_right  <= 1'b0;
      snap_top    <= 1'b0;
      snap_bottom <= 1'b0;
      snap_flip   <= 1'b0;
    end else if (snapshot_c) begin
      snap_left   <= live_left;
      snap_right  <= live_right;
      snap_top    <= live_top;
      snap_bottom <= live_bottom;
      snap_flip   <= live_flip;
    end
  end

  // Bounce, kick and saturating gravity; opposing hits on one axis cancel the bounce.
  always_comb begin
    x_neg_c = x_speed[SPEED_W-1];
    x_pos_c = ~x_speed[SPEED_W-1] & (x_speed != '0);
    y_neg_c = y_speed[SPEED_W-1];
    y_pos_c = ~y_speed[SPEED_W-1] & (y_speed != '0);
    y_grav  = (SPEED_W+1)'(y_speed) + GRAVITY_W;

    x_speed_nxt = x_speed;
    if ((snap_left & ~snap_right & x_neg_c) | (snap_right & ~snap_left & x_pos_c))
      x_speed_nxt = -x_speed;

    if (snap_flip & y_pos_c)
      y_speed_nxt = KICK_SPEED;
    else if ((snap_top & ~snap_bottom & y_neg_c) | (snap_bottom & ~snap_top & y_pos_c))
      y_speed_nxt = -y_speed;
    else if (y_grav > MAX_Y_W)
      y_speed_nxt = SPEED_W'(MAX_Y_SPEED);
    else
      y_speed_nxt = SPEED_W'(y_grav);
  end

  // Speed and position registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      x_speed <= INIT_SPEED_X;
      y_speed <= INIT_SPEED_Y;
      pos_x   <= INIT_POS_X;
      pos_y   <= INIT_POS_Y;
    end else begin
      if (speed_en_c) begin
        x_speed <= x_speed_nxt;
        y_speed <= y_speed_nxt;
      end
      if (pos_en_c) begin
        pos_x <= pos_x + POS_W'(x_speed);
        pos_y <= pos_y + POS_W'(y_speed);
      end
    end
  end

  // Scoring pulse, high during the POS cycle of a frame that saw the flipper.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) flipperHit <= 1'b0;
    else         flipperHit <= flipper_hit_nxt_c;
  end

endmodule

// File: tb/tb_ball_motion.sv
// Self-checking bench for ball_motion: directed table, corner sequences, random frames.
module tb_ball_motion;
  import pinball_pkg::*;

  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame;
  logic [10:0] pixelX, pixelY;
  logic        collisionBorders, collisionFlipper, pause;
  logic [10:0] topLeftX, topLeftY;
  logic        flipperHit;

  always #5 clk = ~clk;

  ball_motion dut (
    .clk              (clk),
    .resetN           (resetN),
    .startOfFrame     (startOfFrame),
    .pixelX           (pixelX),
    .pixelY           (pixelY),
    .collisionBorders (collisionBorders),
    .collisionFlipper (collisionFlipper),
    .pause            (pause),
    .topLeftX         (topLeftX),
    .topLeftY         (topLeftY),
    .flipperHit       (flipperHit)
  );

  int checks = 0;
  int passes = 0;

  // Reference model: integer fixed-point position, speed and accumulated hit sides.
  int mx, my, mvx, mvy;
  bit fl, fr, ft, fb, ff;

  typedef struct {
    int dx; int dy; bit cb; bit cf; bit p;
    int evx; int evy; bit eflip;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int tlx(); return (mx >>> 6) & 2047; endfunction
  function automatic int tly(); return (my >>> 6) & 2047; endfunction

  task automatic model_reset();
    mx = 280 * 64; my = 185 * 64; mvx = 40; mvy = -60;
    fl = 0; fr = 0; ft = 0; fb = 0; ff = 0;
  endtask

  task automatic model_pixel(input int px, input int py, input bit cb, input bit cf);
    if (cb) begin
      if (((px - tlx()) & 2047) < 16) fl = 1; else fr = 1;
      if (((py - tly()) & 2047) < 16) ft = 1; else fb = 1;
    end
    if (cf) ff = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One scan-time collision pixel at offset (dx,dy) from the ball's corner.
  task automatic pixel_event(input int dx, input int dy, input bit cb, input bit cf);
    pixelX = 11'((tlx() + dx) & 2047);
    pixelY = 11'((tly() + dy) & 2047);
    collisionBorders = cb;
    collisionFlipper = cf;
    model_pixel(tlx() + dx, tly() + dy, cb, cf);
    tick();
    collisionBorders = 0;
    collisionFlipper = 0;
  endtask

  // One frame update, optionally with a collision coincident with startOfFrame.
  task automatic run_frame(input bit p, input bit co_cb, input bit co_cf,
                           input int co_dx, input int co_dy, output bit got_flip);
    int ox, oy;
    bit sl, sr, st, sb, sf;
    ox = tlx(); oy = tly();
    pause = p;
    startOfFrame = 1;
    pixelX = 11'((ox + co_dx) & 2047);
    pixelY = 11'((oy + co_dy) & 2047);
    collisionBorders = co_cb;
    collisionFlipper = co_cf;
    sl = fl; sr = fr; st = ft; sb = fb; sf = ff;
    fl = 0; fr = 0; ft = 0; fb = 0; ff = 0;
    model_pixel(ox + co_dx, oy + co_dy, co_cb, co_cf);
    if (!p) begin
      if ((sl && !sr && mvx < 0) || (sr && !sl && mvx > 0)) mvx = -mvx;
      if (sf && mvy > 0) mvy = -300;
      else if ((st && !sb && mvy < 0) || (sb && !st && mvy > 0)) mvy = -mvy;
      else mvy = (mvy + 1 > 380) ? 380 : mvy + 1;
      mx += mvx;
      my += mvy;
    end
    tick();
    startOfFrame = 0; collisionBorders = 0; collisionFlipper = 0;
    check("flip_c1", flipperHit, 0);
    check("x_c1", topLeftX, ox);
    check("y_c1", topLeftY, oy);
    tick();
    got_flip = flipperHit;
    check("flip_c2", flipperHit, sf);
    check("y_c2", topLeftY, oy);
    tick();
    check("flip_c3", flipperHit, 0);
    check("x_c3", topLeftX, tlx());
    check("y_c3", topLeftY, tly());
    check("xspeed", dut.x_speed, mvx);
    check("yspeed", dut.y_speed, mvy);
    pause = 0;
  endtask

  initial begin
    bit gf;
    int vx0, vy0, x0, y0, n;

    resetN = 0; startOfFrame = 0; pixelX = 0; pixelY = 0;
    collisionBorders = 0; collisionFlipper = 0; pause = 0;
    model_reset();
    repeat (3) tick();
    check("rst_x", topLeftX, 280);
    check("rst_y", topLeftY, 185);
    check("rst_flip", flipperHit, 0);
    resetN = 1;
    tick();

    // First frame after reset: only gravity acts.
    run_frame(0, 0, 0, 0, 0, gf);
    check("f0_x", topLeftX, 280);
    check("f0_y", topLeftY, 184);
    check("f0_vy", dut.y_speed, -59);

    // Directed table, hand-computed from speed (40,-59).
    tbl[0] = '{0,  0,  0, 0, 0,  40,  -58, 0};
    tbl[1] = '{3,  20, 1, 0, 0,  40,  -57, 0};
    tbl[2] = '{20, 3,  1, 0, 0, -40,   57, 0};
    tbl[3] = '{5,  5,  0, 1, 0, -40, -300, 1};
    tbl[4] = '{3,  3,  1, 0, 1, -40, -300, 0};
    tbl[5] = '{3,  3,  1, 0, 0,  40,  300, 0};
    tbl[6] = '{20, 20, 1, 1, 0, -40, -300, 1};
    tbl[7] = '{5,  5,  0, 1, 1, -40, -300, 1};
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].cb || tbl[i].cf) pixel_event(tbl[i].dx, tbl[i].dy, tbl[i].cb, tbl[i].cf);
      run_frame(tbl[i].p, 0, 0, 0, 0, gf);
      check($sformatf("tbl%0d_vx", i), dut.x_speed, tbl[i].evx);
      check($sformatf("tbl%0d_vy", i), dut.y_speed, tbl[i].evy);
      check($sformatf("tbl%0d_flip", i), gf, tbl[i].eflip);
      if (i == 5) check("left_cleared", dut.u_det.hitLeft, 0);
    end

    // Opposing left and right hits in one frame leave X speed alone.
    vx0 = mvx;
    pixel_event(3, 10, 1, 0);
    pixel_event(25, 10, 1, 0);
    run_frame(0, 0, 0, 0, 0, gf);
    check("lr_cancel", dut.x_speed, vx0);

    // Hit coincident with startOfFrame belongs to the next frame.
    vx0 = mvx;
    run_frame(0, 1, 0, (vx0 < 0) ? 3 : 25, 10, gf);
    check("coinc_now", dut.x_speed, vx0);
    run_frame(0, 0, 0, 0, 0, gf);
    check("coinc_next", dut.x_speed, -vx0);

    // Pause across three frames, flipper in the middle still scores.
    x0 = tlx(); y0 = tly(); vx0 = mvx; vy0 = mvy;
    run_frame(1, 0, 0, 0, 0, gf);
    pixel_event(5, 5, 0, 1);
    run_frame(1, 0, 0, 0, 0, gf);
    check("pause_flip", gf, 1);
    run_frame(1, 0, 0, 0, 0, gf);
    check("pause_x", topLeftX, x0);
    check("pause_y", topLeftY, y0);
    check("pause_vx", dut.x_speed, vx0);
    check("pause_vy", dut.y_speed, vy0);

    // Climb to 379 then confirm saturation at 380 for two frames.
    n = 0;
    while (mvy != 379 && n < 400) begin
      if (mvy < 0) pixel_event(10, 3, 1, 0);
      run_frame(0, 0, 0, 0, 0, gf);
      n++;
    end
    check("sat_reach", mvy, 379);
    run_frame(0, 0, 0, 0, 0, gf);
    check("sat_1", dut.y_speed, 380);
    run_frame(0, 0, 0, 0, 0, gf);
    check("sat_2", dut.y_speed, 380);
    pixel_event(10, 25, 1, 0);
    run_frame(0, 0, 0, 0, 0, gf);
    check("sat_bounce", dut.y_speed, -380);

    // Randomized frames with wall-steering so the ball stays on screen.
    for (int f = 0; f < 150; f++) begin
      int nev, dx, dy;
      bit cb, cf, p, force_hit;
      nev = $urandom_range(0, 3);
      force_hit = (tlx() > 520 || tlx() < 80 || tly() > 380 || tly() < 60);
      if (force_hit && nev == 0) nev = 1;
      for (int e = 0; e < nev; e++) begin
        dx = $urandom_range(0, 31);
        dy = $urandom_range(0, 31);
        cb = force_hit ? 1'b1 : 1'($urandom_range(0, 1));
        cf = ($urandom_range(0, 5) == 0);
        if (tlx() > 520) dx = 20;
        if (tlx() < 80)  dx = 3;
        if (tly() > 380) dy = 20;
        if (tly() < 60)  dy = 3;
        pixel_event(dx, dy, cb, cf);
      end
      p = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 5) == 0)
        run_frame(p, 1, 1'($urandom_range(0, 1)), $urandom_range(0, 31), $urandom_range(0, 31), gf);
      else
        run_frame(p, 0, 0, 0, 0, gf);
    end

    // Reset asserted during POS restores initial state immediately.
    startOfFrame = 1;
    tick();
    startOfFrame = 0;
    tick();
    check("pre_rst_state", dut.state, POS);
    resetN = 0;
    #1;
    check("rst_pos_x", topLeftX, 280);
    check("rst_pos_y", topLeftY, 185);
    check("rst_pos_flip", flipperHit, 0);
    check("rst_pos_state", dut.state, COLLECT);
    check("rst_pos_vy", dut.y_speed, -60);
    tick();
    resetN = 1;
    model_reset();
    tick();
    run_frame(0, 0, 0, 0, 0, gf);
    check("post_rst_y", topLeftY, 184);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
